change_dispenser: RTL



---
 rtl/retro_vending_pkg.sv | 34 +++
 rtl/change_dispenser_if.sv | 32 +++
 rtl/coin_inventory.sv | 60 ++++++
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/retro_vending_pkg.sv
// Shared types for the retro vending coin path.
// Coin values, FSM states and coin-select encoding.
package retro_vending_pkg;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    EJECT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    C_NONE,
    C_5,
    C_10,
    C_25
  } coin_e;

  function automatic logic [4:0] coin_val(coin_e c);
    logic [4:0] v;
    unique case (c)
      C_25:   v = 5'(COIN_25);
      C_10:   v = 5'(COIN_10);
      C_5:    v = 5'(COIN_5);
      C_NONE: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vending-FSM / hopper side of the change dispenser.
// master drives requests and acks, slave is the dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 7
);

  logic             start;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             coin_ack;
  logic             eject_25;
  logic             eject_10;
  logic             eject_5;
  logic             busy;
  logic             done;
  logic             short;
  logic             jam;
  logic [AMT_W-1:0] remaining;

  modport master (
    output start, amount, refill, coin_ack,
    input  eject_25, eject_10, eject_5,
    input  busy, done, short, jam, remaining
  );

  modport slave (
    input  start, amount, refill, coin_ack,
    output eject_25, eject_10, eject_5,
    output busy, done, short, jam, remaining
  );

endinterface

// File: rtl/coin_inventory.sv
// Per-denomination coin counters for the payout hopper.
// Refill wins over decrement and clear; clear empties a jammed tube.
module coin_inventory
  import retro_vending_pkg::*;
#(
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  refill_i,
  input  coin_e dec_i,
  input  coin_e clr_i,
  output logic  inv_ok_25_o,
  output logic  inv_ok_10_o,
  output logic  inv_ok_5_o
);

  localparam logic [INV_W-1:0] FULL = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] ONE  = INV_W'(1);

  logic [INV_W-1:0] inv25_q, inv25_d;
  logic [INV_W-1:0] inv10_q, inv10_d;
  logic [INV_W-1:0] inv5_q,  inv5_d;

  always_comb begin
    inv25_d = inv25_q;
    inv10_d = inv10_q;
    inv5_d  = inv5_q;
    if (refill_i) begin
      inv25_d = FULL;
      inv10_d = FULL;
      inv5_d  = FULL;
    end else begin
      if (clr_i == C_25)      inv25_d = '0;
      else if (dec_i == C_25) inv25_d = inv25_q - ONE;
      if (clr_i == C_10)      inv10_d = '0;
      else if (dec_i == C_10) inv10_d = inv10_q - ONE;
      if (clr_i == C_5)       inv5_d  = '0;
      else if (dec_i == C_5)  inv5_d  = inv5_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv25_q <= FULL;
      inv10_q <= FULL;
      inv5_q  <= FULL;
    end else begin
      inv25_q <= inv25_d;
      inv10_q <= inv10_d;
      inv5_q  <= inv5_d;
    end
  end

  assign inv_ok_25_o = |inv25_q;
  assign inv_ok_10_o = |inv10_q;
  assign inv_ok_5_o  = |inv5_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy 25/10/5 change payout with hopper handshake.
// CHANGE_ACK_TIMEOUT_EN adds an ack-timeout jam detector.
module change_dispenser
  import retro_vending_pkg::*;
#(
  parameter int AMT_W    = 7,
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
`ifdef CHANGE_ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input logic clk,
  input logic reset_n,
  change_dispenser_if.slave bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  coin_e            coin_q, coin_d;
  coin_e            pick, dec, clr;
  logic             short_q, short_d;
  logic             refill_go;
  logic             ok25, ok10, ok5;

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jam_q, jam_d;
`endif

  coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inv (
    .clk         (clk),
    .rst_n       (reset_n),
    .refill_i    (refill_go),
    .dec_i       (dec),
    .clr_i       (clr),
    .inv_ok_25_o (ok25),
    .inv_ok_10_o (ok10),
    .inv_ok_5_o  (ok5)
  );

  // Largest affordable coin that is still in stock
  always_comb begin
    pick = C_NONE;
    if (ok25 && rem_q >= AMT_W'(COIN_25))      pick = C_25;
    else if (ok10 && rem_q >= AMT_W'(COIN_10)) pick = C_10;
    else if (ok5 && rem_q >= AMT_W'(COIN_5))   pick = C_5;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    coin_d    = coin_q;
    short_d   = short_q;
    dec       = C_NONE;
    clr       = C_NONE;
    refill_go = 1'b0;
`ifdef CHANGE_ACK_TIMEOUT_EN
    cnt_d     = cnt_q;
    jam_d     = jam_q;
`endif
    unique case (state_q)
      IDLE: begin
        refill_go = bus.refill;
        if (bus.start) begin
          rem_d   = bus.amount;
          short_d = 1'b0;
`ifdef CHANGE_ACK_TIMEOUT_EN
          jam_d   = 1'b0;
`endif
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (pick != C_NONE) begin
          coin_d  = pick;
`ifdef CHANGE_ACK_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = EJECT;
        end else begin
          short_d = (rem_q != '0);
          state_d = DONE;
        end
      end
      EJECT: begin
        if (bus.coin_ack) begin
          rem_d   = rem_q - AMT_W'(coin_val(coin_q));
          dec     = coin_q;
          coin_d  = C_NONE;
          state_d = SELECT;
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          clr     = coin_q;
          coin_d  = C_NONE;
          short_d = 1'b1;
          jam_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q   <= '0;
      coin_q  <= C_NONE;
      short_q <= 1'b0;
`ifdef CHANGE_ACK_TIMEOUT_EN
      cnt_q   <= '0;
      jam_q   <= 1'b0;
`endif
    end else begin
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      short_q <= short_d;
`ifdef CHANGE_ACK_TIMEOUT_EN
      cnt_q   <= cnt_d;
      jam_q   <= jam_d;
`endif
    end
  end

  always_comb begin
    bus.eject_25 = 1'b0;
    bus.eject_10 = 1'b0;
    bus.eject_5  = 1'b0;
    bus.busy     = (state_q != IDLE);
    bus.done     = (state_q == DONE);
    if (state_q == EJECT) begin
      unique case (1'b1)
        (coin_q == C_25): bus.eject_25 = 1'b1;
        (coin_q == C_10): bus.eject_10 = 1'b1;
        (coin_q == C_5):  bus.eject_5  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.remaining = rem_q;
  assign bus.short     = short_q;
`ifdef CHANGE_ACK_TIMEOUT_EN
  assign bus.jam       = jam_q;
`else
  assign bus.jam       = 1'b0;
`endif

endmodule
